// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display.
// Content is double-buffered; a new word reaches the display only at a frame boundary or while scanning is disabled.
module seg_scan_ctrl #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  blank_in,
   output logic [7:0]  seg_out,
   output logic [7:0]  seg_en,
   output logic        frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

   logic [PW-1:0] presc;
   logic [2:0]    idx;
   logic          tick;
   logic          boundary;

   logic          pend_full;
   logic          pend_full_nxt;
   logic [31:0]   pend_data;
   logic [7:0]    pend_dp;
   logic [7:0]    pend_blank;
   logic [31:0]   act_data;
   logic [7:0]    act_dp;
   logic [7:0]    act_blank;
   logic          accept;
   logic          apply;
   logic          bnd_p0;
   logic [3:0]    nib;

   function automatic logic [6:0] seg7_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1110011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   always_comb begin
      tick          = en && (presc == PRESC_MAX);
      boundary      = tick && (idx == 3'd7);
      accept        = upd_valid && upd_ready;
      // A full buffer cannot accept, so apply and accept never collide.
      apply         = pend_full && (boundary || !en);
      pend_full_nxt = pend_full;
      if (apply)
         pend_full_nxt = 1'b0;
      else if (accept)
         pend_full_nxt = 1'b1;
      nib           = act_data[{idx, 2'b00} +: 4];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (!en) begin
         presc <= '0;
         idx   <= '0;
      end else if (tick) begin
         presc <= '0;
         idx   <= idx + 3'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_full  <= 1'b0;
         upd_ready  <= 1'b1;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         act_data   <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
      end else begin
         pend_full <= pend_full_nxt;
         upd_ready <= !pend_full_nxt;
         if (accept) begin
            pend_data  <= data_in;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
         end
         if (apply) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
         end
      end
   end

   // Stage p0: boundary delayed so frame_done lines up with digit 0 on the pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         bnd_p0 <= 1'b0;
      else
         bnd_p0 <= boundary;
   end

   // Output stage: one cycle behind the digit index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_out    <= '0;
         seg_en     <= '0;
         frame_done <= 1'b0;
      end else if (!en) begin
         seg_out    <= '0;
         seg_en     <= '0;
         frame_done <= 1'b0;
      end else begin
         seg_en     <= 8'h01 << idx;
         seg_out    <= act_blank[idx] ? 8'h00 : {seg7_decode(nib), act_dp[idx]};
         frame_done <= bnd_p0;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SCAN_DIV = 4 (32-cycle frames).
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [31:0] data_in = '0;
   logic [7:0]  dp_in = '0;
   logic [7:0]  blank_in = '0;
   logic [7:0]  seg_out;
   logic [7:0]  seg_en;
   logic        frame_done;

   seg_scan_ctrl #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
      .seg_out(seg_out), .seg_en(seg_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  blank;
      logic [63:0] exp;
   } vec_t;

   vec_t       tbl [4];
   logic [6:0] seg7 [16];
   int         checks = 0;
   int         errors = 0;
   int         ur_ones;
   logic       ur_last;

   function automatic logic [63:0] model(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 8; k++)
         r[8*k +: 8] = bl[k] ? 8'h00 : {seg7[(d >> (4*k)) & 32'hF], dp[k]};
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_fd();
      int  n = 0;
      bit  done = 0;
      ur_ones = 0;
      ur_last = 1'b0;
      while (!done) begin
         @(negedge clk);
         n++;
         if (frame_done) done = 1;
         else begin
            ur_ones += int'(upd_ready);
            ur_last = upd_ready;
            if (n > 200) begin
               chk("frame_done_timeout", 64'd1, 64'd0);
               done = 1;
            end
         end
      end
   endtask

   task automatic send(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl, input bit keep);
      int n = 0;
      upd_valid = 1'b1;
      data_in   = d;
      dp_in     = dp;
      blank_in  = bl;
      while (!upd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("upd_ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      if (!keep) upd_valid = 1'b0;
   endtask

   // Called at the negedge where digit 0 first appears; returns at the next frame_done negedge.
   task automatic check_frame(input logic [63:0] e, input string tag);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s_en%0d", tag, k), 64'(seg_en), 64'(8'h01 << k));
         chk($sformatf("%s_seg%0d", tag, k), 64'(seg_out), 64'(e[8*k +: 8]));
         @(negedge clk);
         chk($sformatf("%s_fd_low%0d", tag, k), 64'(frame_done), 64'd0);
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("%s_en_hold%0d", tag, k), 64'(seg_en), 64'(8'h01 << k));
         @(negedge clk);
      end
      chk($sformatf("%s_fd", tag), 64'(frame_done), 64'd1);
   endtask

   task automatic check_handoff(input string tag);
      chk($sformatf("%s_ready_rise", tag), 64'(ur_last), 64'd1);
      chk($sformatf("%s_ready_low", tag), 64'(ur_ones), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] cur;
      logic [63:0] ea, eb, ec, er;
      logic [31:0] rd;
      logic [7:0]  rdp, rbl;
      int          off, dig;

      seg7 = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
               7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
      tbl[0] = '{32'h89ABCDEF, 8'h01, 8'h00, 64'hFEE6EE3E9C7A9E8F};
      tbl[1] = '{32'h12345678, 8'h00, 8'h0F, 64'h60DAF26600000000};
      tbl[2] = '{32'h01234567, 8'hFF, 8'h00, 64'hFD61DBF367B7BFE1};
      tbl[3] = '{32'hFFFFFFFF, 8'hAA, 8'h81, 64'h008E8F8E8F8E8F00};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_seg_out", 64'(seg_out), 64'd0);
      chk("rst_seg_en", 64'(seg_en), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_upd_ready", 64'(upd_ready), 64'd1);
      rst = 1'b1;
      en  = 1'b1;
      @(negedge clk);
      chk("start_en", 64'(seg_en), 64'h01);
      chk("start_seg", 64'(seg_out), 64'hFC);

      // Plain scan of zeros
      cur = 64'hFCFCFCFCFCFCFCFC;
      wait_fd();
      check_frame(cur, "zero");

      // Table vectors: accept mid-frame, old content holds until the boundary
      for (int i = 0; i < 4; i++) begin
         off = 6 + 4 * i;
         repeat (off) @(negedge clk);
         send(tbl[i].data, tbl[i].dp, tbl[i].blank, 1'b0);
         dig = (off + 1) / 4;
         chk($sformatf("tbl%0d_ready_drop", i), 64'(upd_ready), 64'd0);
         chk($sformatf("tbl%0d_old_seg", i), 64'(seg_out), 64'(cur[8*dig +: 8]));
         wait_fd();
         check_handoff($sformatf("tbl%0d", i));
         check_frame(tbl[i].exp, $sformatf("tbl%0d", i));
         cur = tbl[i].exp;
      end

      // Back-to-back words with upd_valid held high
      ea = model(32'hDEADBEEF, 8'h00, 8'h00);
      eb = model(32'h76543210, 8'h80, 8'h00);
      fork
         begin
            send(32'hDEADBEEF, 8'h00, 8'h00, 1'b1);
            send(32'h76543210, 8'h80, 8'h00, 1'b0);
         end
         begin
            wait_fd();
            check_frame(ea, "b2b_a");
            check_frame(eb, "b2b_b");
         end
      join

      // Disable at digit 5, load while disabled, re-enable
      repeat (20) @(negedge clk);
      chk("en_digit5", 64'(seg_en), 64'h20);
      en = 1'b0;
      @(negedge clk);
      chk("dis_seg_en", 64'(seg_en), 64'd0);
      chk("dis_seg_out", 64'(seg_out), 64'd0);
      chk("dis_fd", 64'(frame_done), 64'd0);
      send(32'hC0FFEE42, 8'h10, 8'h00, 1'b0);
      chk("dis_ready_drop", 64'(upd_ready), 64'd0);
      @(negedge clk);
      chk("dis_ready_back", 64'(upd_ready), 64'd1);
      chk("dis_seg_en_hold", 64'(seg_en), 64'd0);
      en = 1'b1;
      @(negedge clk);
      ec = model(32'hC0FFEE42, 8'h10, 8'h00);
      check_frame(ec, "reen");

      // Asynchronous reset with the pending buffer full
      repeat (5) @(negedge clk);
      send(32'h13579BDF, 8'hFF, 8'h00, 1'b0);
      chk("pre_rst_ready", 64'(upd_ready), 64'd0);
      #2 rst = 1'b0;
      #1;
      chk("arst_seg_out", 64'(seg_out), 64'd0);
      chk("arst_seg_en", 64'(seg_en), 64'd0);
      chk("arst_fd", 64'(frame_done), 64'd0);
      chk("arst_ready", 64'(upd_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      wait_fd();
      check_frame(64'hFCFCFCFCFCFCFCFC, "post_rst");

      // Randomized words against the model
      for (int i = 0; i < 6; i++) begin
         rd  = $urandom;
         rdp = 8'($urandom);
         rbl = 8'($urandom) & 8'($urandom);
         er  = model(rd, rdp, rbl);
         repeat ($urandom_range(1, 20)) @(negedge clk);
         send(rd, rdp, rbl, 1'b0);
         wait_fd();
         check_handoff($sformatf("rnd%0d", i));
         check_frame(er, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an 8-digit common-segment seven-segment display.
- Holds a 32-bit hex word (8 nibbles) plus per-digit decimal-point and blank masks.
- Sequences one digit at a time and hex-decodes the selected nibble onto the shared segment bus.
- Takes new display content through a valid/ready handshake and applies it only at frame boundaries, so a frame never shows mixed data.
- Sits between application logic (counters, FSM status) and the board display pins.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 ms per digit, 125 Hz frame); legal range >= 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
en  input  1  scan enable; low blanks the display and holds the scan at digit 0
upd_valid  input  1  new display content offered
upd_ready  output  1  pending buffer empty, update can be accepted
data_in  input  32  nibble k (bits 4k+3:4k) drives digit k
dp_in  input  8  bit k lights the decimal point of digit k
blank_in  input  8  bit k blanks digit k entirely
seg_out  output  8  segments {a,b,c,d,e,f,g,dp}, MSB = a, active-high
seg_en  output  8  one-hot digit enable, active-high, bit k = digit k
frame_done  output  1  one-cycle pulse when a new frame starts

Behaviour:
- Reset (rst low, asynchronous), all registers cleared:
  - prescaler = 0, digit index = 0, pending buffer empty, active data/dp/blank = 0.
  - Outputs: seg_out = 0, seg_en = 0, frame_done = 0, upd_ready = 1 (registered, from the empty flag).
- Handshake:
  - Transfer occurs when upd_valid && upd_ready on a rising edge. It latches data_in, dp_in and blank_in into the pending buffer and marks it full.
  - upd_ready = !pending_full. It is registered, so it drops on the cycle after the accept.
  - upd_valid may stay high while upd_ready is low; no data is lost or duplicated.
- Prescaler:
  - While en = 1, counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted when prescaler = SCAN_DIV-1.
- Digit index:
  - Advances on tick, 0 to 7, then wraps to 0.
  - A tick at index 7 is the frame boundary.
- Frame boundary (tick at index 7):
  - If the pending buffer is full, copy it to the active registers and clear the full flag. upd_ready rises the next cycle.
  - frame_done pulses for 1 cycle, registered and coincident with seg_en showing digit 0.
- Simultaneous accept and boundary in the same cycle:
  - Only possible when the pending buffer was empty.
  - The new word is stored in pending and applied at the next boundary, not this one.
- en = 0:
  - Prescaler and index forced to 0; seg_out = 0 and seg_en = 0 on the next cycle; frame_done = 0.
  - The handshake keeps working. A full pending buffer is copied to the active registers immediately (next edge), so re-enabling shows the latest content from digit 0.
- Output pipeline:
  - seg_out and seg_en are registered from the current index and active registers: 1-cycle latency after an index change.
  - seg_en = 1 << index.
  - Blanked digit: seg_out = 8'h00 (dp also off) while seg_en still selects the digit, keeping brightness uniform.
- Decode, nibble to seg_out[7:1]; seg_out[0] = dp bit:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1110011, A:1110111, B:0011111, C:1001110, D:0111101, E:1001111, F:1000111
- Reset mid-frame: immediate return to the reset state. Pending and active contents are discarded.

Test Plan:
1. SCAN_DIV=4, rst low then high, en=1, no update:
   - seg_en walks 01,02,04,...,80,01 with every step 4 cycles.
   - seg_out = 8'hFC ("0") on every digit.
   - frame_done pulses every 32 cycles.
2. Accept data_in=32'h89ABCDEF, dp_in=8'h01, blank_in=0 mid-frame:
   - Digits keep showing 0 until the boundary.
   - Then digit0 = 8'h8F (F with dp), digit1 = 8'h9E (E), digit7 = 8'hFE (8).
   - upd_ready stays low from accept until the cycle after the boundary.
3. Hold upd_valid high with two words back-to-back:
   - Second word is accepted only after the first is applied.
   - Each word is displayed for at least one full frame; none is skipped.
4. Set blank_in=8'h0F, data=32'h12345678:
   - Digits 0-3 give seg_out=00 with seg_en still active.
   - Digit4 gives 8'h66 (4), digit5 gives 8'hF2 (3).
5. Drop en mid-frame at index 5 and load a word while en=0:
   - Next cycle seg_en=0 and seg_out=0.
   - On en=1 the scan restarts at digit 0 showing the new word.
6. Assert rst low asynchronously between clk edges with the pending buffer full:
   - All outputs go to 0 immediately and upd_ready goes to 1.
   - After release the display shows 0s.
